// File: rtl/ysyx_commit_flush_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_commit_flush_ctrl
//
// Commit-side flush/fence sequencer. It sits between the WBU retire stream
// and the front end. When a retiring instruction asks for a pipeline flush,
// a system retire, a fence or a fence.i, this block does the following:
//   1. pulses `flush` for one cycle to squash younger work,
//   2. holds `stall_commit` so the ROB stops retiring,
//   3. waits for the store buffer to drain (fence / fence.i),
//   4. requests an I-cache invalidate (fence.i only),
//   5. redirects fetch to the retired instruction's npc.
// It also keeps a saturating count of stalled commit cycles for perf.
//
// Every output is decoded from registered state. No input reaches an
// output combinationally.
//
// Ports:
//   clock             core clock
//   reset             synchronous, active-high reset
//   retire_valid      one instruction retires this cycle
//   retire_pc         pc of the retiring instruction (trace only)
//   retire_npc        architectural next pc of the retiring instruction
//   retire_flush_pipe retiring instruction needs a pipeline flush
//   retire_sys        system-instruction retire, handled like a flush
//   retire_fence_time fence: drain the store buffer before refetch
//   retire_fence_i    fence.i: drain, then invalidate the I-cache
//   sb_empty          store buffer has no pending stores
//   icache_inv_ack    I-cache invalidate done (single-cycle pulse)
//   flush             one-cycle squash pulse to IFU/IDU/ROB/RS
//   redirect_valid    one-cycle fetch redirect strobe
//   redirect_pc       redirect target, 0 when no redirect is issued
//   icache_inv_req    level request to invalidate the I-cache
//   stall_commit      ROB must not retire this cycle
//   stall_cycles      saturating count of cycles with stall_commit=1
// ---------------------------------------------------------------------------
module ysyx_commit_flush_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             retire_valid,
   input  logic [XLEN-1:0]  retire_pc,
   input  logic [XLEN-1:0]  retire_npc,
   input  logic             retire_flush_pipe,
   input  logic             retire_sys,
   input  logic             retire_fence_time,
   input  logic             retire_fence_i,
   input  logic             sb_empty,
   input  logic             icache_inv_ack,
   output logic             flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             icache_inv_req,
   output logic             stall_commit,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      INVAL = 2'd2,
      REDIR = 2'd3
   } state_t;

   // Which kind of sequence is in flight. Flush and sys share one kind
   // because they follow the same path.
   typedef enum logic [1:0] {
      K_NONE    = 2'd0,
      K_FLUSH   = 2'd1,
      K_FENCE   = 2'd2,
      K_FENCE_I = 2'd3
   } kind_t;

   state_t           state;
   kind_t            kind;
   kind_t            trig_kind;
   logic [XLEN-1:0]  tgt;
   logic             flush_q;
   logic [CNT_W-1:0] stall_cnt;

   // Pick the highest-priority request flag:
   // fence.i > fence > flush_pipe = sys.
   // NOTE: every variable written in always_comb gets a default first,
   // so that no path through the block can infer a latch.
   always_comb begin
      trig_kind = K_NONE;
      if (retire_fence_i)
         trig_kind = K_FENCE_I;
      else if (retire_fence_time)
         trig_kind = K_FENCE;
      else if (retire_flush_pipe || retire_sys)
         trig_kind = K_FLUSH;
   end

   // NOTE: sequential state uses non-blocking assignments only. All
   // registers then update together at the edge, whatever order the
   // statements appear in.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         kind      <= K_NONE;
         tgt       <= '0;
         flush_q   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         // The flush pulse lasts one cycle unless a new trigger sets it below.
         flush_q <= 1'b0;

         if (stall_commit && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);

         unique case (state)
            IDLE: begin
               // In IDLE, flush_q is always 0, so stall_commit is low. Any
               // retire here is legal. A retire with no flags does nothing.
               if (retire_valid && (trig_kind != K_NONE)) begin
                  tgt     <= retire_npc;
                  kind    <= trig_kind;
                  flush_q <= 1'b1;
                  state   <= (trig_kind == K_FLUSH) ? REDIR : DRAIN;
               end
            end
            DRAIN: begin
               if (sb_empty)
                  state <= (kind == K_FENCE_I) ? INVAL : REDIR;
            end
            INVAL: begin
               if (icache_inv_ack)
                  state <= REDIR;
            end
            REDIR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign flush          = flush_q;
   assign redirect_valid = (state == REDIR);
   assign redirect_pc    = (state == REDIR) ? tgt : '0;
   assign icache_inv_req = (state == INVAL);
   assign stall_commit   = (state != IDLE) || flush_q;
   assign stall_cycles   = stall_cnt;

   // A retire while commit is stalled breaks the protocol. The FSM ignores
   // it (no relatch) and this check flags it in simulation. The report is a
   // warning, so the run keeps going.
   always @(posedge clock) begin
      if (!reset && retire_valid && stall_commit)
         assert (1'b0)
         else $warning("retire while commit stalled ignored: pc=%h npc=%h",
                       retire_pc, retire_npc);
   end

endmodule

// File: tb/tb_ysyx_commit_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_commit_flush_ctrl
//
// Directed bench for the commit flush/fence sequencer. Inputs change #1
// after the rising edge. Outputs are checked in that same window, so each
// check sees the state registered at the preceding edge. The DUT runs with
// an 8-bit stall counter, so the saturation path is reached by plain
// stimulus. Expected counts are worked out by hand per sequence.
// ---------------------------------------------------------------------------
module tb_ysyx_commit_flush_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             retire_valid;
   logic [XLEN-1:0]  retire_pc;
   logic [XLEN-1:0]  retire_npc;
   logic             retire_flush_pipe;
   logic             retire_sys;
   logic             retire_fence_time;
   logic             retire_fence_i;
   logic             sb_empty;
   logic             icache_inv_ack;
   logic             flush;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             icache_inv_req;
   logic             stall_commit;
   logic [CNT_W-1:0] stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   ysyx_commit_flush_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clock             (clock),
      .reset             (reset),
      .retire_valid      (retire_valid),
      .retire_pc         (retire_pc),
      .retire_npc        (retire_npc),
      .retire_flush_pipe (retire_flush_pipe),
      .retire_sys        (retire_sys),
      .retire_fence_time (retire_fence_time),
      .retire_fence_i    (retire_fence_i),
      .sb_empty          (sb_empty),
      .icache_inv_ack    (icache_inv_ack),
      .flush             (flush),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .icache_inv_req    (icache_inv_req),
      .stall_commit      (stall_commit),
      .stall_cycles      (stall_cycles)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic f, input logic rv,
                             input logic [XLEN-1:0] pc, input logic req,
                             input logic st);
      check({tag, ".flush"},    64'(flush),          64'(f));
      check({tag, ".redir_v"},  64'(redirect_valid), 64'(rv));
      check({tag, ".redir_pc"}, 64'(redirect_pc),    64'(pc));
      check({tag, ".inv_req"},  64'(icache_inv_req), 64'(req));
      check({tag, ".stall"},    64'(stall_commit),   64'(st));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_retire();
      retire_valid      = 1'b0;
      retire_flush_pipe = 1'b0;
      retire_sys        = 1'b0;
      retire_fence_time = 1'b0;
      retire_fence_i    = 1'b0;
   endtask

   initial begin
      // Hold reset from time 0. The other inputs start X, then go to 0.
      reset = 1'b1;
      #2;
      clear_retire();
      retire_pc      = '0;
      retire_npc     = '0;
      sb_empty       = 1'b0;
      icache_inv_ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      tick();
      check_outs("reset", 0, 0, 32'h0, 0, 0);
      check("reset.cnt", 64'(stall_cycles), 64'd0);

      // A retire with no flags set does nothing.
      retire_valid = 1'b1;
      retire_npc   = 32'h0000_1234;
      tick();
      clear_retire();
      check_outs("noflag", 0, 0, 32'h0, 0, 0);

      // flush_pipe: flush and redirect both at T+1, IDLE at T+2.
      retire_valid      = 1'b1;
      retire_flush_pipe = 1'b1;
      retire_pc         = 32'h8000_00fc;
      retire_npc        = 32'h8000_0100;
      tick();
      clear_retire();
      check_outs("flush_t1", 1, 1, 32'h8000_0100, 0, 1);
      tick();
      check_outs("flush_t2", 0, 0, 32'h0, 0, 0);
      exp_cnt += 1;
      check("flush.cnt", 64'(stall_cycles), 64'(exp_cnt));

      // sys: handled exactly like a flush.
      retire_valid = 1'b1;
      retire_sys   = 1'b1;
      retire_npc   = 32'h8000_0200;
      tick();
      clear_retire();
      check_outs("sys_t1", 1, 1, 32'h8000_0200, 0, 1);
      tick();
      check_outs("sys_t2", 0, 0, 32'h0, 0, 0);
      exp_cnt += 1;

      // fence: store buffer busy for T+1..T+4, empty at T+5, redirect T+6.
      retire_valid      = 1'b1;
      retire_fence_time = 1'b1;
      retire_npc        = 32'h8000_0040;
      sb_empty          = 1'b0;
      tick();
      clear_retire();
      check_outs("fence_t1", 1, 0, 32'h0, 0, 1);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check_outs("fence_drain", 0, 0, 32'h0, 0, 1);
      end
      tick();
      sb_empty = 1'b1;
      check_outs("fence_t5", 0, 0, 32'h0, 0, 1);
      tick();
      sb_empty = 1'b0;
      check_outs("fence_t6", 0, 1, 32'h8000_0040, 0, 1);
      tick();
      check_outs("fence_t7", 0, 0, 32'h0, 0, 0);
      exp_cnt += 6;
      check("fence.cnt", 64'(stall_cycles), 64'(exp_cnt));

      // fence.i: the drain is immediate. A stray ack at T+1 is ignored.
      // req is high T+2..T+5, ack arrives at T+5, redirect at T+6.
      retire_valid   = 1'b1;
      retire_fence_i = 1'b1;
      retire_npc     = 32'h8000_2004;
      sb_empty       = 1'b1;
      tick();
      clear_retire();
      icache_inv_ack = 1'b1;
      check_outs("fi_t1", 1, 0, 32'h0, 0, 1);
      tick();
      icache_inv_ack = 1'b0;
      check_outs("fi_t2", 0, 0, 32'h0, 1, 1);
      tick();
      check_outs("fi_t3", 0, 0, 32'h0, 1, 1);
      tick();
      check_outs("fi_t4", 0, 0, 32'h0, 1, 1);
      tick();
      icache_inv_ack = 1'b1;
      check_outs("fi_t5", 0, 0, 32'h0, 1, 1);
      tick();
      icache_inv_ack = 1'b0;
      check_outs("fi_t6", 0, 1, 32'h8000_2004, 0, 1);
      tick();
      check_outs("fi_t7", 0, 0, 32'h0, 0, 0);
      exp_cnt += 6;
      check("fi.cnt", 64'(stall_cycles), 64'(exp_cnt));

      // fence.i with flush_pipe: the fence.i path wins. A retire during
      // DRAIN is ignored (no relatch), so the original npc is kept.
      retire_valid      = 1'b1;
      retire_fence_i    = 1'b1;
      retire_flush_pipe = 1'b1;
      retire_npc        = 32'h8000_3000;
      sb_empty          = 1'b0;
      tick();
      clear_retire();
      check_outs("prio_t1", 1, 0, 32'h0, 0, 1);
      tick();
      retire_valid      = 1'b1;
      retire_flush_pipe = 1'b1;
      retire_npc        = 32'hdead_beef;
      tick();
      clear_retire();
      sb_empty = 1'b1;
      check_outs("prio_t3", 0, 0, 32'h0, 0, 1);
      tick();
      icache_inv_ack = 1'b1;
      check_outs("prio_t4", 0, 0, 32'h0, 1, 1);
      tick();
      icache_inv_ack = 1'b0;
      check_outs("prio_t5", 0, 1, 32'h8000_3000, 0, 1);
      tick();
      check_outs("prio_t6", 0, 0, 32'h0, 0, 0);
      exp_cnt += 5;
      check("prio.cnt", 64'(stall_cycles), 64'(exp_cnt));

      // Reset during INVAL aborts the sequence. No redirect follows.
      retire_valid   = 1'b1;
      retire_fence_i = 1'b1;
      retire_npc     = 32'h8000_4000;
      sb_empty       = 1'b1;
      tick();
      clear_retire();
      tick();
      check_outs("rinv_t2", 0, 0, 32'h0, 1, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_outs("rinv_t3", 0, 0, 32'h0, 0, 0);
      check("rinv.cnt", 64'(stall_cycles), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_outs("rinv_after", 0, 0, 32'h0, 0, 0);
      end

      // Saturation. A fence with 252 busy drain cycles gives 254 stalled
      // cycles (253 DRAIN + 1 REDIR). A 3-cycle stall then saturates the
      // counter at 255.
      retire_valid      = 1'b1;
      retire_fence_time = 1'b1;
      retire_npc        = 32'h8000_5000;
      sb_empty          = 1'b0;
      tick();
      clear_retire();
      for (int i = 1; i < 252; i++) tick();
      tick();
      sb_empty = 1'b1;
      tick();
      check_outs("sat_redir", 0, 1, 32'h8000_5000, 0, 1);
      tick();
      check("sat.cnt254", 64'(stall_cycles), 64'd254);

      retire_valid      = 1'b1;
      retire_fence_time = 1'b1;
      retire_npc        = 32'h8000_6000;
      sb_empty          = 1'b0;
      tick();
      clear_retire();
      tick();
      sb_empty = 1'b1;
      tick();
      check_outs("sat2_redir", 0, 1, 32'h8000_6000, 0, 1);
      tick();
      check("sat.cnt255", 64'(stall_cycles), 64'd255);
      tick();
      tick();
      check("sat.hold", 64'(stall_cycles), 64'd255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
